// File: rtl/keylock_send_sequencer.sv
// keylock_send_sequencer
//
// Feeds a multi-digit key code, one 4-bit digit at a time, into the
// single-digit sender block. For each digit it raises snd_enabled, waits for
// the sender's active pulse to come and go, then keeps snd_enabled low for a
// fixed gap before the next digit. Digit 0 (code[3:0]) goes first.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   - an ARM-state watchdog aborts the sequence and sets the
//               sticky err flag if the sender never raises active.
//   undefined - ARM waits indefinitely; err is tied low.
//
// Ports
//   hwclk       in   clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   begin a sequence (only looked at while idle)
//   code        in   4*DIGITS packed digits, digit i at [4i+3:4i]
//   len         in   digits to send, clamped to DIGITS
//   abort       in   cancel the running sequence
//   snd_active  in   sender active output
//   snd_num     out  digit presented to the sender
//   snd_enabled out  enable to the sender
//   busy        out  sequence in progress
//   done        out  one-cycle pulse on normal completion
//   err         out  sticky watchdog timeout flag
module keylock_send_sequencer #(
    parameter int DIGITS     = 4,
    parameter int GAP_CYCLES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  hwclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   code,
    input  logic [2:0]            len,
    input  logic                  abort,
    input  logic                  snd_active,
    output logic [3:0]            snd_num,
    output logic                  snd_enabled,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [3:0]            num_q, num_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   code_q;
    logic [2:0]            len_q;
    logic                  latch;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0]            wdog_q, wdog_d;
    logic                  err_q, err_d;
`endif

    function automatic logic [2:0] clamp_len(input logic [2:0] l);
        if (l > 3'(DIGITS))
            return 3'(DIGITS);
        return l;
    endfunction

    // Constant-index selection avoids a variable part-select whose index
    // width would not match the code vector.
    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] c,
                                            input logic [2:0] i);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++)
            if (i == 3'(k))
                r = c[4*k +: 4];
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        num_d   = num_q;
        en_d    = en_q;
        done_d  = 1'b0;
        latch   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    idx_d = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d  = 1'b0;
                    wdog_d = '0;
`endif
                    if (clamp_len(len) == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ARM;
                        en_d    = 1'b1;
                        num_d   = code[3:0];
                    end
                end
            end
            S_ARM: begin
                if (snd_active) begin
                    state_d = S_HOLD;
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (wdog_q == 8'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (!snd_active) begin
                    state_d = S_GAP;
                    en_d    = 1'b0;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (idx_q == len_q - 3'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        num_d   = digit_at(code_q, idx_q + 3'd1);
                        en_d    = 1'b1;
                        state_d = S_ARM;
`ifdef SEQ_TIMEOUT_EN
                        wdog_d  = '0;
`endif
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything else, including a same-cycle timeout,
        // and leaves err as it was.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
            err_d   = err_q;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            num_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched code/len are pure data; they are only read while busy.
    always_ff @(posedge hwclk) begin
        if (latch) begin
            code_q <= code;
            len_q  <= clamp_len(len);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign snd_num     = num_q;
    assign snd_enabled = en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_keylock_send_sequencer.sv
// Directed bench for keylock_send_sequencer (DIGITS=4, GAP_CYCLES=3,
// TIMEOUT=10). Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, i.e. after the registers have settled.
module tb_keylock_send_sequencer;

    logic        hwclk;
    logic        reset;
    logic        start;
    logic [15:0] code;
    logic [2:0]  len;
    logic        abort;
    logic        snd_active;
    logic [3:0]  snd_num;
    logic        snd_enabled;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    keylock_send_sequencer #(
        .DIGITS(4),
        .GAP_CYCLES(3),
        .TIMEOUT(10)
    ) dut (
        .hwclk(hwclk),
        .reset(reset),
        .start(start),
        .code(code),
        .len(len),
        .abort(abort),
        .snd_active(snd_active),
        .snd_num(snd_num),
        .snd_enabled(snd_enabled),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    // Called just after the edge where snd_enabled rose for this digit.
    // The sender model holds active for 5 cycles, then the 3-cycle gap runs.
    task automatic do_digit(input logic [3:0] expn, input bit last);
        chk("arm_en", 8'(snd_enabled), 8'd1);
        chk("arm_num", 8'(snd_num), 8'(expn));
        chk("arm_busy", 8'(busy), 8'd1);
        snd_active = 1'b1;
        repeat (5) begin
            step();
            chk("hold_en", 8'(snd_enabled), 8'd1);
            chk("hold_num", 8'(snd_num), 8'(expn));
        end
        snd_active = 1'b0;
        repeat (3) begin
            step();
            chk("gap_en", 8'(snd_enabled), 8'd0);
            chk("gap_done", 8'(done), 8'd0);
            chk("gap_busy", 8'(busy), 8'd1);
        end
        step();
        if (last) begin
            chk("end_done", 8'(done), 8'd1);
            chk("end_busy", 8'(busy), 8'd0);
            chk("end_en", 8'(snd_enabled), 8'd0);
            step();
            chk("after_done", 8'(done), 8'd0);
            chk("after_num", 8'(snd_num), 8'(expn));
        end else begin
            chk("next_en", 8'(snd_enabled), 8'd1);
            chk("next_done", 8'(done), 8'd0);
        end
    endtask

    task automatic kick(input logic [15:0] c, input logic [2:0] l);
        code  = c;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        code       = '0;
        len        = '0;
        abort      = 1'b0;
        snd_active = 1'b0;
        #1;
        chk("rst_num", 8'(snd_num), 8'd0);
        chk("rst_en", 8'(snd_enabled), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_busy", 8'(busy), 8'd0);

        // Basic four-digit sequence
        kick(16'h4321, 3'd4);
        do_digit(4'h1, 1'b0);
        do_digit(4'h2, 1'b0);
        do_digit(4'h3, 1'b0);
        do_digit(4'h4, 1'b1);
        step();
        chk("idle_hold_num", 8'(snd_num), 8'h4);
        chk("idle_busy2", 8'(busy), 8'd0);

        // Zero length: done one cycle after start, no enable
        kick(16'h9999, 3'd0);
        chk("len0_done", 8'(done), 8'd1);
        chk("len0_en", 8'(snd_enabled), 8'd0);
        chk("len0_busy", 8'(busy), 8'd0);
        step();
        chk("len0_done_low", 8'(done), 8'd0);
        chk("len0_en2", 8'(snd_enabled), 8'd0);

        // len=7 clamped to 4 digits
        kick(16'h8765, 3'd7);
        do_digit(4'h5, 1'b0);
        do_digit(4'h6, 1'b0);
        do_digit(4'h7, 1'b0);
        do_digit(4'h8, 1'b1);
        step();
        chk("clamp_en", 8'(snd_enabled), 8'd0);

        // Abort during HOLD of digit 2; values above 9 pass through
        kick(16'hFEDC, 3'd4);
        do_digit(4'hC, 1'b0);
        do_digit(4'hD, 1'b0);
        chk("ab_num", 8'(snd_num), 8'hE);
        snd_active = 1'b1;
        step();
        step();
        chk("ab_hold_en", 8'(snd_enabled), 8'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        snd_active = 1'b0;
        chk("ab_en", 8'(snd_enabled), 8'd0);
        chk("ab_busy", 8'(busy), 8'd0);
        chk("ab_done", 8'(done), 8'd0);
        step();
        chk("ab_done2", 8'(done), 8'd0);
        chk("ab_num_hold", 8'(snd_num), 8'hE);
        kick(16'h4321, 3'd2);
        do_digit(4'h1, 1'b0);
        do_digit(4'h2, 1'b1);

        // start / code / len changes while busy are ignored
        kick(16'h9876, 3'd3);
        code  = 16'h1111;
        len   = 3'd1;
        start = 1'b1;
        do_digit(4'h6, 1'b0);
        start = 1'b0;
        do_digit(4'h7, 1'b0);
        do_digit(4'h8, 1'b1);
        step();
        chk("ign_busy", 8'(busy), 8'd0);

        // Sender never answers
        kick(16'h0005, 3'd1);
        chk("to_en0", 8'(snd_enabled), 8'd1);
        chk("to_num", 8'(snd_num), 8'h5);
`ifdef SEQ_TIMEOUT_EN
        repeat (9) begin
            step();
            chk("to_wait_en", 8'(snd_enabled), 8'd1);
            chk("to_wait_err", 8'(err), 8'd0);
        end
        step();
        chk("to_en", 8'(snd_enabled), 8'd0);
        chk("to_err", 8'(err), 8'd1);
        chk("to_done", 8'(done), 8'd0);
        chk("to_busy", 8'(busy), 8'd0);
        step();
        chk("to_err_sticky", 8'(err), 8'd1);
        chk("to_done2", 8'(done), 8'd0);
        kick(16'h0003, 3'd1);
        chk("to_err_clr", 8'(err), 8'd0);
        do_digit(4'h3, 1'b1);
`else
        repeat (20) begin
            step();
            chk("wait_en", 8'(snd_enabled), 8'd1);
            chk("wait_err", 8'(err), 8'd0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("wait_ab_en", 8'(snd_enabled), 8'd0);
        chk("wait_ab_busy", 8'(busy), 8'd0);
        chk("wait_ab_done", 8'(done), 8'd0);
        chk("wait_ab_err", 8'(err), 8'd0);
`endif

        // Reset asserted mid-cycle while in GAP
        kick(16'h4321, 3'd4);
        snd_active = 1'b1;
        step();
        step();
        snd_active = 1'b0;
        step();
        chk("rg_gap_en", 8'(snd_enabled), 8'd0);
        chk("rg_gap_busy", 8'(busy), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rg_num", 8'(snd_num), 8'd0);
        chk("rg_en", 8'(snd_enabled), 8'd0);
        chk("rg_busy", 8'(busy), 8'd0);
        chk("rg_done", 8'(done), 8'd0);
        chk("rg_err", 8'(err), 8'd0);
        step();
        reset = 1'b0;
        step();
        chk("rg_idle_busy", 8'(busy), 8'd0);
        kick(16'h0002, 3'd1);
        do_digit(4'h2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keylock_send_sequencer.md
# keylock_send_sequencer

Sequences a multi-digit key code through the single-digit `sender` block. It latches up to `DIGITS` 4-bit digits on a start request and presents them one at a time on the sender's `num`/`enabled` inputs. For each digit it runs the `enabled` → `active` → release handshake, then inserts a fixed idle gap. Sits between the keypad/code-entry logic and `sender`. It is the only driver of the sender's `num` and `enabled`.

## Interface
Parameters:
- `DIGITS`, 4: maximum digits per code (1..7).
- `GAP_CYCLES`, 3: idle cycles with `snd_enabled`=0 between digits (≥1).
- `TIMEOUT`, 255: cycles allowed for `snd_active` to rise after `snd_enabled` is asserted (≥1, fits 8 bits).

Ports:
- `hwclk`, in, 1: system clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request to send; sampled only in IDLE.
- `code`, in, 4*DIGITS: digit i at bits [4i+3:4i]; digit 0 is sent first.
- `len`, in, 3: number of digits to send; values >DIGITS are clamped to DIGITS.
- `abort`, in, 1: cancel the current sequence.
- `snd_active`, in, 1: `sender` `active` output.
- `snd_num`, out, 4: to `sender` `num`.
- `snd_enabled`, out, 1: to `sender` `enabled`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when a sequence completes normally.
- `err`, out, 1: sticky timeout flag (see Configuration).

## Operation
- States: IDLE, ARM, HOLD, GAP.
- IDLE:
  - On `start`=1, latch `code` and `clamp(len)` into internal registers, clear `err`, and set idx=0.
  - If the clamped len=0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to ARM.
- ARM:
  - Drive `snd_num`=digit[idx] and `snd_enabled`=1.
  - On `snd_active`=1, go to HOLD.
- HOLD:
  - Keep `snd_enabled`=1 and `snd_num` stable.
  - On `snd_active`=0, go to GAP.
- GAP:
  - `snd_enabled`=0 and the gap counter counts GAP_CYCLES cycles.
  - At expiry: if idx=len−1, pulse `done` and go to IDLE; else idx+1 and go to ARM.
- `snd_num` only changes when entering ARM and holds its value otherwise. In IDLE it holds the last value sent.
- `abort` in any non-IDLE state:
  - Next cycle goes to IDLE with `snd_enabled`=0.
  - No `done` pulse; `err` is unchanged.
- `abort` takes priority over every other transition in the same cycle.
- `start` while busy is ignored; it is not queued.
- Latched code/len are unaffected by changes on `code`/`len` while busy.
- Digit values 10–15 are passed through unchanged. Range checking is the sender's concern.

## Timing
- Reset values:
  - State IDLE, idx=0.
  - `snd_num`=0, `snd_enabled`=0.
  - `busy`=0, `done`=0, `err`=0.
- Reset mid-sequence drops `snd_enabled` immediately (asynchronous).
- All outputs are registered.
- `start` sampled at edge N → `snd_enabled`=1 and `snd_num`=digit0 from edge N+1.
- `snd_active` falls at edge M → `snd_enabled`=0 from edge M+1.
- The next digit's `snd_enabled` rises GAP_CYCLES cycles after `snd_enabled` falls.
- `done` is high for exactly the cycle in which state returns to IDLE. `busy` is 0 in that same cycle.
- The idx counter is 3 bits and never wraps, because len is clamped.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts while in ARM and resets on entering ARM.
  - If it reaches TIMEOUT with `snd_active` still 0: set `err`=1, drive `snd_enabled`=0, go to IDLE, and do not pulse `done`.
  - `err` stays set until the next accepted `start` or `reset`.
- `SEQ_TIMEOUT_EN` undefined:
  - ARM waits indefinitely.
  - `err` is tied to 0 and no watchdog logic is instantiated.

## Test plan
- Basic sequence: `code`=16'h4321, `len`=4, sender model holds active for 5 cycles per digit. Expect `snd_num` to step 1, 2, 3, 4; exactly 4 enabled pulses separated by 3 idle cycles; one `done` pulse; `busy` low afterwards.
- Clamp and zero length: `len`=0 → `done` one cycle after `start`, no enabled pulse. `len`=7 with DIGITS=4 → exactly 4 digits sent.
- Abort: `abort` asserted during HOLD of digit 2 → `snd_enabled`=0 next cycle, no `done`. A following `start` sends from digit 0.
- Start and code change while busy: second `start` and `code` change during a sequence → ignored, and the original digits complete.
- Timeout, with `SEQ_TIMEOUT_EN` and TIMEOUT=10: sender never raises active → `snd_enabled` drops after 10 cycles in ARM, `err`=1, no `done`. The next `start` clears `err`.
- Reset mid-sequence: `reset` pulsed in GAP → all outputs 0 asynchronously; state IDLE.
